// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings for univ_shift_reg and anything that drives its mode input.
package univ_shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_LOAD  = 3'b001;
  localparam mode_t MODE_SHL   = 3'b010;
  localparam mode_t MODE_SHR   = 3'b011;
  localparam mode_t MODE_ROL   = 3'b100;
  localparam mode_t MODE_ROR   = 3'b101;
  localparam mode_t MODE_CNTUP = 3'b110;
  localparam mode_t MODE_CNTDN = 3'b111;

endpackage

// File: rtl/univ_shift_reg_bit.sv
// One-bit storage cell with synchronous active-low reset to a per-bit reset value.
module reg_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic qbar_o
);

  logic q_q;

  // Reset branch first so X on the next-value path cannot leak in during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= rst_val_i;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o    = q_q;
  assign qbar_o = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold/load/shift/rotate/count with enable and terminal count.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sol,
  output logic             sor,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RstVal = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  q_d = d;
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], sil};
        MODE_SHR:   q_d = {sir, q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_CNTUP: q_d = q_q + One;
        MODE_CNTDN: q_d = q_q - One;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .rst_val_i (RstVal[i]),
      .d_i       (q_d[i]),
      .q_o       (q_q[i]),
      .qbar_o    (qbar[i])
    );
  end

  assign q   = q_q;
  assign sol = q_q[WIDTH-1];
  assign sor = q_q[0];

  // High the cycle before a wrap so a cascaded upper stage can use it as its enable.
  assign tc = en & (((mode == MODE_CNTUP) & (&q_q)) | ((mode == MODE_CNTDN) & ~(|q_q)));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: main DUT, a RESET_VAL=8'h3C DUT and a two-stage cascade.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic       rst_n = 1'b0, en = 1'b0, sil = 1'b0, sir = 1'b0;
  mode_t      mode = MODE_HOLD;
  logic [7:0] d = 8'h00;
  logic [7:0] q0, qb0;
  logic       sol0, sor0, tc0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(32'h0)) u_main (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sil(sil), .sir(sir),
    .q(q0), .qbar(qb0), .sol(sol0), .sor(sor0), .tc(tc0)
  );

  // Non-zero reset value DUT, held by en=0 after reset
  logic [7:0] q1, qb1;
  logic       sol1, sor1, tc1;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(32'h3C)) u_rv (
    .clk(clk), .rst_n(rst_n), .en(1'b0), .mode(MODE_LOAD), .d(8'hFF), .sil(1'b0), .sir(1'b0),
    .q(q1), .qbar(qb1), .sol(sol1), .sor(sor1), .tc(tc1)
  );

  // Cascade: lower tc drives upper en
  logic       c_rst_n = 1'b0, c_en = 1'b0;
  logic [7:0] q2, qb2, q3, qb3;
  logic       sol2, sor2, tc2, sol3, sor3, tc3;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(32'h0)) u_lo (
    .clk(clk), .rst_n(c_rst_n), .en(c_en), .mode(MODE_CNTUP), .d(8'h00), .sil(1'b0), .sir(1'b0),
    .q(q3), .qbar(qb3), .sol(sol3), .sor(sor3), .tc(tc3)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(32'h0)) u_hi (
    .clk(clk), .rst_n(c_rst_n), .en(tc3), .mode(MODE_CNTUP), .d(8'h00), .sil(1'b0), .sir(1'b0),
    .q(q2), .qbar(qb2), .sol(sol2), .sor(sor2), .tc(tc2)
  );

  typedef struct {
    int         cyc;
    int         which;   // 0 main, 1 reset-value DUT, 2 cascade upper, 3 cascade lower
    string      name;
    logic [7:0] q;
    logic       tc;
    bit         chk_tc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input string nm, input logic [7:0] eq, input logic etc,
                      input bit ctc);
    exp_t e;
    e.cyc = cyc; e.which = which; e.name = nm; e.q = eq; e.tc = etc; e.chk_tc = ctc;
    sb.push_back(e);
  endtask

  // Advance one edge, apply inputs for the next edge, expect main q (from the edge just taken)
  // and tc (from that q with the newly applied inputs).
  task automatic step(input string nm, input logic r, input logic e, input mode_t m,
                      input logic [7:0] dv, input logic sl, input logic sr,
                      input logic [7:0] eq, input logic etc);
    tick();
    rst_n = r; en = e; mode = m; d = dv; sil = sl; sir = sr;
    push(0, nm, eq, etc, 1'b1);
  endtask

  // Monitor: compare every expectation due at this sample point
  initial begin
    exp_t       e;
    logic [7:0] aq, aqb;
    logic       asol, asor, atc;
    bit         bad;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.which)
          0:       begin aq = q0; aqb = qb0; asol = sol0; asor = sor0; atc = tc0; end
          1:       begin aq = q1; aqb = qb1; asol = sol1; asor = sor1; atc = tc1; end
          2:       begin aq = q2; aqb = qb2; asol = sol2; asor = sor2; atc = tc2; end
          default: begin aq = q3; aqb = qb3; asol = sol3; asor = sor3; atc = tc3; end
        endcase
        bad = 1'b0;
        if (e.cyc != cyc) begin
          $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
          bad = 1'b1;
        end
        if (aq !== e.q) begin
          $display("FAIL %s q: got %h, required %h", e.name, aq, e.q);
          bad = 1'b1;
        end
        if (aqb !== ~e.q) begin
          $display("FAIL %s qbar: got %h, required %h", e.name, aqb, ~e.q);
          bad = 1'b1;
        end
        if (asol !== e.q[7] || asor !== e.q[0]) begin
          $display("FAIL %s sol/sor: got %b/%b, required %b/%b", e.name, asol, asor,
                   e.q[7], e.q[0]);
          bad = 1'b1;
        end
        if (e.chk_tc && atc !== e.tc) begin
          $display("FAIL %s tc: got %b, required %b", e.name, atc, e.tc);
          bad = 1'b1;
        end
        n_cmp++;
        if (bad) n_err++;
      end
    end
  end

  initial begin
    // Reset edge happens with rst_n=0 from time 0
    step("rst",       1, 1, MODE_LOAD,  8'hA5, 0, 0, 8'h00, 0);
    push(1, "rst_val3c", 8'h3C, 1'b0, 1'b1);
    step("load_a5",   1, 1, MODE_SHL,   8'h00, 1, 0, 8'hA5, 0);
    step("shl",       1, 1, MODE_SHR,   8'h00, 0, 0, 8'h4B, 0);
    step("shr",       1, 1, MODE_LOAD,  8'h81, 0, 0, 8'h25, 0);
    step("load_81a",  1, 1, MODE_ROL,   8'h00, 0, 0, 8'h81, 0);
    step("rol",       1, 1, MODE_LOAD,  8'h81, 0, 0, 8'h03, 0);
    step("load_81b",  1, 1, MODE_ROR,   8'h00, 0, 0, 8'h81, 0);
    step("ror",       1, 1, MODE_LOAD,  8'hFE, 0, 0, 8'hC0, 0);
    step("load_fe",   1, 1, MODE_CNTUP, 8'h00, 0, 0, 8'hFE, 0);
    step("up_ff_tc",  1, 1, MODE_CNTUP, 8'h00, 0, 0, 8'hFF, 1);
    step("up_wrap",   1, 1, MODE_LOAD,  8'h01, 0, 0, 8'h00, 0);
    step("load_01",   1, 1, MODE_CNTDN, 8'h00, 0, 0, 8'h01, 0);
    step("dn_00_tc",  1, 1, MODE_CNTDN, 8'h00, 0, 0, 8'h00, 1);
    // Wrap to FF, then hold with en=0 even though CNTUP at all-ones would flag tc
    step("dn_wrap",   1, 0, MODE_CNTUP, 8'h00, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 5; i++) begin
      step("en0_hold", 1, 0, MODE_CNTUP, 8'h00, 0, 0, 8'hFF, 0);
    end
    step("en1_hold",  1, 1, MODE_HOLD,  8'h00, 0, 0, 8'hFF, 0);
    step("hold",      1, 1, MODE_LOAD,  8'h7F, 0, 0, 8'hFF, 0);
    // Reset asserted mid-count at 7F must give 00, not 80
    step("load_7f",   0, 1, MODE_CNTUP, 8'h00, 0, 0, 8'h7F, 0);
    step("rst_prio",  1, 1, MODE_CNTUP, 8'h00, 0, 0, 8'h00, 0);
    step("resume1",   1, 1, MODE_CNTUP, 8'h00, 0, 0, 8'h01, 0);
    step("resume2",   1, 1, MODE_LOAD,  8'h5A, 0, 0, 8'h02, 0);
    // X on mode/en during reset must not corrupt the reset result
    tick();
    rst_n = 1'b0; en = 1'bx; mode = 3'bxxx; d = 8'hxx;
    push(0, "pre_xrst", 8'h5A, 1'b0, 1'b0);
    step("x_rst",     1, 0, MODE_HOLD,  8'h00, 0, 0, 8'h00, 0);

    // Cascade: release reset, then 256 enabled edges
    tick();
    c_rst_n = 1'b0;
    tick();
    c_rst_n = 1'b1; c_en = 1'b1;
    push(3, "casc_lo0", 8'h00, 1'b0, 1'b1);
    push(2, "casc_hi0", 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 255; i++) tick();
    push(3, "casc_lo_ff", 8'hFF, 1'b1, 1'b1);
    push(2, "casc_hi_00", 8'h00, 1'b0, 1'b1);
    tick();
    push(3, "casc_lo_wrap", 8'h00, 1'b0, 1'b1);
    push(2, "casc_hi_01", 8'h01, 1'b0, 1'b1);

    tick();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      n_err++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
